// File: rtl/posit_mac_sched.sv
// Sequencer that streams K weight/activation posit pairs per output into one posit_mac,
// waits for each result, writes it to the result memory and enforces the MAC's idle gap.
module posit_mac_sched #(
    parameter int WIDTH   = 8,
    parameter int K       = 1,
    parameter int AW      = 8,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             start_i,
    input  logic [AW-1:0]    n_out_i,
    input  logic [AW-1:0]    w_base_i,
    input  logic [AW-1:0]    d_base_i,
    input  logic [AW-1:0]    r_base_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             w_rd_en_o,
    output logic [AW-1:0]    w_addr_o,
    input  logic [WIDTH-1:0] w_rdata_i,
    output logic             d_rd_en_o,
    output logic [AW-1:0]    d_addr_o,
    input  logic [WIDTH-1:0] d_rdata_i,
    output logic             mac_vld_o,
    output logic [WIDTH-1:0] mac_win_o,
    output logic [WIDTH-1:0] mac_din_o,
    input  logic             mac_vld_i,
    input  logic [WIDTH-1:0] mac_acc_i,
    output logic             r_wr_en_o,
    output logic [AW-1:0]    r_addr_o,
    output logic [WIDTH-1:0] r_wdata_o
);
    localparam int KW = $clog2(K + 1);
    localparam int TW = $clog2(((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    j_q, n_out_q, d_base_q, r_base_q;
    logic [AW-1:0]    w_addr_q, d_addr_q, r_addr_q;
    logic [KW-1:0]    k_q;
    logic [TW-1:0]    t_q;
    logic             busy_q, done_q, err_q, rd_en_q, mac_vld_q, vld_prev_q, r_wr_en_q;
    logic [WIDTH-1:0] r_wdata_q;

    logic mac_edge, last_k, last_j, gap_end, drain_expired;

    // Only the rising edge of mac_vld_i marks a new result; a held-high valid is ignored.
    assign mac_edge      = mac_vld_i & ~vld_prev_q;
    assign last_k        = (k_q == KW'(K - 1));
    assign last_j        = (j_q == n_out_q - AW'(1));
    assign gap_end       = (t_q == TW'(GAP - 1));
    assign drain_expired = (t_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            n_out_q    <= '0;
            d_base_q   <= '0;
            r_base_q   <= '0;
            w_addr_q   <= '0;
            d_addr_q   <= '0;
            r_addr_q   <= '0;
            k_q        <= '0;
            t_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            mac_vld_q  <= 1'b0;
            vld_prev_q <= 1'b0;
            r_wr_en_q  <= 1'b0;
            r_wdata_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            r_wr_en_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            mac_vld_q  <= rd_en_q;
            vld_prev_q <= mac_vld_i;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (n_out_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            n_out_q  <= n_out_i;
                            d_base_q <= d_base_i;
                            r_base_q <= r_base_i;
                            j_q      <= '0;
                            k_q      <= '0;
                            w_addr_q <= w_base_i;
                            d_addr_q <= d_base_i;
                            rd_en_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_k) begin
                        t_q     <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        k_q      <= k_q + KW'(1);
                        w_addr_q <= w_addr_q + AW'(1);
                        d_addr_q <= d_addr_q + AW'(1);
                        rd_en_q  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mac_edge) begin
                        r_wdata_q <= mac_acc_i;
                        r_addr_q  <= r_base_q + j_q;
                        r_wr_en_q <= 1'b1;
                        state_q   <= S_WRITE;
                    end else if (drain_expired) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                S_WRITE: begin
                    t_q     <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (!gap_end) begin
                        t_q <= t_q + TW'(1);
                    end else if (last_j) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Weights of consecutive outputs are contiguous, so the pointer just continues.
                        j_q      <= j_q + AW'(1);
                        k_q      <= '0;
                        w_addr_q <= w_addr_q + AW'(1);
                        d_addr_q <= d_base_q;
                        rd_en_q  <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign w_rd_en_o = rd_en_q;
    assign d_rd_en_o = rd_en_q;
    assign w_addr_o  = w_addr_q;
    assign d_addr_o  = d_addr_q;
    assign mac_vld_o = mac_vld_q;
    assign mac_win_o = mac_vld_q ? w_rdata_i : '0;
    assign mac_din_o = mac_vld_q ? d_rdata_i : '0;
    assign r_wr_en_o = r_wr_en_q;
    assign r_addr_o  = r_addr_q;
    assign r_wdata_o = r_wdata_q;

endmodule

// File: tb/tb_posit_mac_sched.sv
// Directed + randomized bench for posit_mac_sched with behavioural memories, MAC and timing reference.
module tb_posit_mac_sched;
    localparam int WIDTH = 8, K = 4, AW = 8, GAP = 16, TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start_i = 1'b0;
    logic [AW-1:0] n_out_i = '0, w_base_i = '0, d_base_i = '0, r_base_i = '0;
    logic busy_o, done_o, err_o, w_rd_en_o, d_rd_en_o, mac_vld_o, r_wr_en_o;
    logic [AW-1:0] w_addr_o, d_addr_o, r_addr_o;
    logic [WIDTH-1:0] w_rdata = '0, d_rdata = '0, mac_win_o, mac_din_o, r_wdata_o;
    logic mac_vld_i = 1'b0;
    logic [WIDTH-1:0] mac_acc_i = '0;

    posit_mac_sched #(.WIDTH(WIDTH), .K(K), .AW(AW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst(rst), .start_i(start_i), .n_out_i(n_out_i),
        .w_base_i(w_base_i), .d_base_i(d_base_i), .r_base_i(r_base_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .w_rd_en_o(w_rd_en_o), .w_addr_o(w_addr_o), .w_rdata_i(w_rdata),
        .d_rd_en_o(d_rd_en_o), .d_addr_o(d_addr_o), .d_rdata_i(d_rdata),
        .mac_vld_o(mac_vld_o), .mac_win_o(mac_win_o), .mac_din_o(mac_din_o),
        .mac_vld_i(mac_vld_i), .mac_acc_i(mac_acc_i),
        .r_wr_en_o(r_wr_en_o), .r_addr_o(r_addr_o), .r_wdata_o(r_wdata_o)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffer memories.
    logic [WIDTH-1:0] w_mem [256];
    logic [WIDTH-1:0] d_mem [256];
    always @(posedge clk) begin
        if (w_rd_en_o) w_rdata <= w_mem[w_addr_o];
        if (d_rd_en_o) d_rdata <= d_mem[d_addr_o];
    end

    // Behavioural MAC: accumulates K products, answers rsp_delay cycles after the last valid.
    int rsp_delay = 17, rsp_hold = 1, mcnt = 0, rsp_at = -1, hold_left = 0;
    bit mac_answer_en = 1'b1, mac_fixed_en = 1'b0;
    logic [WIDTH-1:0] mac_fixed = '0, macc = '0, rsp_val = '0;
    logic [15:0] prod;
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0; macc = '0; rsp_at = -1; hold_left = 0;
            mac_vld_i = 1'b0; mac_acc_i = '0;
        end else begin
            if (mac_vld_o) begin
                prod = {8'b0, mac_win_o} * {8'b0, mac_din_o};
                macc = macc + prod[7:0];
                mcnt++;
                if (mcnt == K) begin
                    rsp_val = mac_fixed_en ? mac_fixed : macc;
                    rsp_at  = cyc + rsp_delay;
                    mcnt = 0; macc = '0;
                end
            end
            if (cyc == rsp_at && mac_answer_en) hold_left = rsp_hold;
            if (hold_left > 0) begin
                mac_vld_i = 1'b1; mac_acc_i = rsp_val; hold_left--;
            end else begin
                mac_vld_i = 1'b0; mac_acc_i = WIDTH'($urandom);
            end
        end
    end

    // Event logs, sampled mid-cycle.
    int rd_cyc[$], rd_w[$], rd_d[$], vld_cyc[$], wr_cyc[$], wr_addr[$], wr_data[$];
    int done_cyc[$], done_busy[$], err_rise[$];
    int en_mis = 0, busy_cnt = 0;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (w_rd_en_o) begin rd_cyc.push_back(cyc); rd_w.push_back(int'(w_addr_o)); rd_d.push_back(int'(d_addr_o)); end
            if (w_rd_en_o != d_rd_en_o) en_mis++;
            if (mac_vld_o) vld_cyc.push_back(cyc);
            if (r_wr_en_o) begin wr_cyc.push_back(cyc); wr_addr.push_back(int'(r_addr_o)); wr_data.push_back(int'(r_wdata_o)); end
            if (done_o) begin done_cyc.push_back(cyc); done_busy.push_back(int'(busy_o)); end
            if (busy_o) busy_cnt++;
            if (err_o && !err_prev) err_rise.push_back(cyc);
        end
        err_prev = rst ? 1'b0 : err_o;
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_w.delete(); rd_d.delete(); vld_cyc.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_cyc.delete(); done_busy.delete(); err_rise.delete();
        en_mis = 0; busy_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_dot(input int j, input int wb, input int db);
        int s = 0;
        for (int k = 0; k < K; k++)
            s += int'(w_mem[(wb + j * K + k) % 256]) * int'(d_mem[(db + k) % 256]);
        return s % 256;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({busy_o, done_o, err_o, w_rd_en_o, w_addr_o, d_rd_en_o, d_addr_o, mac_vld_o,
                    mac_win_o, mac_din_o, r_wr_en_o, r_addr_o, r_wdata_o});
    endfunction

    task automatic do_start(input int n, input int wb, input int db, input int rb, output int c0);
        @(negedge clk);
        n_out_i = AW'(n); w_base_i = AW'(wb); d_base_i = AW'(db); r_base_i = AW'(rb);
        start_i = 1'b1; c0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Full batch against the reference: reads, MAC valids, writes, done timing.
    task automatic run_batch(input string tag, input int n, input int wb, input int db, input int rb,
                             input int delay, input int hold, input bit fixed, input int fval, input int mid_at);
        int c0, i, c, ridx, budget;
        clear_logs();
        rsp_delay = delay; rsp_hold = hold; mac_fixed_en = fixed; mac_fixed = WIDTH'(fval); mac_answer_en = 1'b1;
        do_start(n, wb, db, rb, c0);
        if (mid_at > 0) begin
            while (cyc < c0 + mid_at) @(negedge clk);
            n_out_i = '0; w_base_i = AW'($urandom); r_base_i = AW'($urandom); start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        budget = n * (K + delay + 2 + GAP) + 40;
        for (int b = 0; b < budget && done_cyc.size() == 0; b++) @(negedge clk);
        repeat (6) @(negedge clk);
        i = c0 + 1; ridx = 0;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < K; k++) begin
                chk({tag, ".rd_cyc"}, 64'(rd_cyc[ridx]), 64'(i + k));
                chk({tag, ".w_addr"}, 64'(rd_w[ridx]), 64'((wb + j * K + k) % 256));
                chk({tag, ".d_addr"}, 64'(rd_d[ridx]), 64'((db + k) % 256));
                chk({tag, ".vld_cyc"}, 64'(vld_cyc[ridx]), 64'(i + k + 1));
                ridx++;
            end
            c = i + K + delay;
            chk({tag, ".wr_cyc"}, 64'(wr_cyc[j]), 64'(c + 1));
            chk({tag, ".wr_addr"}, 64'(wr_addr[j]), 64'((rb + j) % 256));
            chk({tag, ".wr_data"}, 64'(wr_data[j]), 64'(fixed ? fval : ref_dot(j, wb, db)));
            i = c + 2 + GAP;
        end
        chk({tag, ".rd_count"}, 64'(rd_cyc.size()), 64'(n * K));
        chk({tag, ".vld_count"}, 64'(vld_cyc.size()), 64'(n * K));
        chk({tag, ".wr_count"}, 64'(wr_cyc.size()), 64'(n));
        chk({tag, ".done_count"}, 64'(done_cyc.size()), 64'd1);
        chk({tag, ".done_cyc"}, 64'(done_cyc[0]), 64'(i));
        chk({tag, ".busy_at_done"}, 64'(done_busy[0]), 64'd0);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(i - c0 - 1));
        chk({tag, ".err"}, 64'(err_o), 64'd0);
        chk({tag, ".en_match"}, 64'(en_mis), 64'd0);
    endtask

    initial begin
        int c0;
        for (int a = 0; a < 256; a++) begin w_mem[a] = WIDTH'($urandom); d_mem[a] = WIDTH'($urandom); end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;

        // Basic single output with a fixed MAC answer.
        run_batch("single", 1, 8'h10, 8'h20, 8'h30, 17, 1, 1'b1, 8'h5A, 0);

        // Three outputs, held MAC valid must not retrigger.
        run_batch("multi", 3, 0, 0, int'($urandom_range(0, 255)), int'($urandom_range(3, 40)), 2, 1'b0, 0, 0);

        // Weight address wrap.
        run_batch("wrap", 2, 8'hFE, int'($urandom_range(0, 255)), 8'hFF, int'($urandom_range(1, 30)), 1, 1'b0, 0, 0);

        // Timeout: MAC never answers.
        clear_logs();
        mac_answer_en = 1'b0;
        do_start(2, 8'h40, 8'h50, 8'h60, c0);
        while (cyc < c0 + K + 1 + TIMEOUT + 6) @(negedge clk);
        chk("tmo.err_rise_count", 64'(err_rise.size()), 64'd1);
        chk("tmo.err_rise_cyc", 64'(err_rise[0]), 64'(c0 + K + 1 + TIMEOUT));
        chk("tmo.done_count", 64'(done_cyc.size()), 64'd1);
        chk("tmo.done_cyc", 64'(done_cyc[0]), 64'(c0 + K + 1 + TIMEOUT));
        chk("tmo.no_write", 64'(wr_cyc.size()), 64'd0);
        chk("tmo.rd_count", 64'(rd_cyc.size()), 64'(K));
        chk("tmo.err_sticky", 64'(err_o), 64'd1);
        chk("tmo.idle", 64'(busy_o), 64'd0);
        mac_answer_en = 1'b1;

        // n_out = 0: immediate done, clears the sticky error, no reads.
        clear_logs();
        do_start(0, 8'h11, 8'h22, 8'h33, c0);
        chk("zero.err_cleared", 64'(err_o), 64'd0);
        repeat (5) @(negedge clk);
        chk("zero.done_count", 64'(done_cyc.size()), 64'd1);
        chk("zero.done_cyc", 64'(done_cyc[0]), 64'(c0 + 1));
        chk("zero.no_reads", 64'(rd_cyc.size()), 64'd0);
        chk("zero.no_busy", 64'(busy_cnt), 64'd0);

        // start_i during DRAIN is ignored.
        run_batch("midstart", 2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 20, 1, 1'b0, 0, K + 6);

        // Reset during ISSUE, then restart.
        clear_logs();
        do_start(3, 8'h70, 8'h80, 8'h90, c0);
        while (cyc < c0 + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue.outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        repeat (GAP + 4) @(negedge clk);
        run_batch("after_rst", 2, 8'h70, 8'h80, 8'h90, int'($urandom_range(1, 40)), 1, 1'b0, 0, 0);

        // Randomized batches.
        for (int r = 0; r < 4; r++)
            run_batch("rand", int'($urandom_range(1, 4)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(1, 50)), int'($urandom_range(1, 3)), 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
